sm_ahb_ram_slow: RTL and testbench

AHB-Lite slave providing word-addressed on-chip "slow" RAM with a configurable number of wait states. Sits directly downstream of the core's AHB-Lite host adapter, on the bus that carries the 0x20000000–0xffffffff address window. It gives the host side a realistic multi-cycle target: HREADY stretching, pipelined address/data phases, and error responses.

---
 rtl/sm_ahb_pkg.sv | 20 ++
 rtl/sm_ahb_ram_array.sv | 24 ++
 rtl/sm_ahb_ram_slow.sv | 128 ++++++++++++
 tb/tb_sm_ahb_ram_slow.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/sm_ahb_pkg.sv
// Shared AHB-Lite encodings and slave FSM states for the sm_ahb slave family.
package sm_ahb_pkg;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   localparam logic HRESP_OKAY  = 1'b0;
   localparam logic HRESP_ERROR = 1'b1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT,
      S_DATA,
      S_ERR1,
      S_ERR2
   } state_t;

endpackage

// File: rtl/sm_ahb_ram_array.sv
// SIZE x 32 storage: synchronous write port, asynchronous read port.
module sm_ahb_ram_array #(
   parameter int unsigned SIZE = 64,
   parameter int unsigned AW   = $clog2(SIZE)
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] wa,
   input  logic [31:0]   wd,
   input  logic [AW-1:0] ra,
   output logic [31:0]   rd
);

   logic [31:0] mem [SIZE];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[wa] <= wd;
      end
   end

   assign rd = mem[ra];

endmodule

// File: rtl/sm_ahb_ram_slow.sv
// AHB-Lite word-addressed RAM slave with WAIT_CYCLES wait states per data phase.
// Define SM_AHB_RAM_ERR_EN to build ERROR responses for out-of-range/misaligned accesses.
module sm_ahb_ram_slow
   import sm_ahb_pkg::*;
#(
   parameter int unsigned SIZE        = 64,
   parameter logic [31:0] BASE        = 32'h2000_0000,
   parameter int unsigned WAIT_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        HSEL,
   input  logic [31:0] HADDR,
   input  logic        HWRITE,
   input  logic [1:0]  HTRANS,
   input  logic [31:0] HWDATA,
   input  logic        HREADY,
   output logic [31:0] HRDATA,
   output logic        HREADYOUT,
   output logic        HRESP
);

   localparam int unsigned AW = $clog2(SIZE);

   state_t        state, state_nxt, issue_state;
   logic [3:0]    cnt, cnt_nxt, issue_cnt;
   logic [AW-1:0] addr_r;
   logic          write_r;
   logic [31:0]   offset;
   logic          addr_err;
   logic          accept;
   logic          we;
   logic [31:0]   rd;
   logic          unused_bits;

   assign offset      = HADDR - BASE;
   assign accept      = HSEL & HTRANS[1] & HREADY & HREADYOUT;
   assign unused_bits = ^{HTRANS[0], offset[1:0], offset[31:AW+2]};

`ifdef SM_AHB_RAM_ERR_EN
   assign addr_err = (offset >= 32'(SIZE * 4)) || (HADDR[1:0] != 2'b00);
`else
   assign addr_err = 1'b0;
`endif

   // Where a newly accepted transfer goes; shared by IDLE, DATA and ERR2.
   always_comb begin
      issue_state = S_IDLE;
      issue_cnt   = cnt;
      if (accept) begin
         if (addr_err) begin
            issue_state = S_ERR1;
         end else if (WAIT_CYCLES > 0) begin
            issue_state = S_WAIT;
            issue_cnt   = 4'(WAIT_CYCLES - 1);
         end else begin
            issue_state = S_DATA;
         end
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      HREADYOUT = 1'b1;
      HRESP     = HRESP_OKAY;
      case (state)
         S_IDLE, S_DATA: begin
            state_nxt = issue_state;
            cnt_nxt   = issue_cnt;
         end
         S_WAIT: begin
            HREADYOUT = 1'b0;
            if (cnt == 4'd0) begin
               state_nxt = S_DATA;
            end else begin
               cnt_nxt = cnt - 4'd1;
            end
         end
`ifdef SM_AHB_RAM_ERR_EN
         S_ERR1: begin
            HREADYOUT = 1'b0;
            HRESP     = HRESP_ERROR;
            state_nxt = S_ERR2;
         end
         S_ERR2: begin
            HRESP     = HRESP_ERROR;
            state_nxt = issue_state;
            cnt_nxt   = issue_cnt;
         end
`endif
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= S_IDLE;
         cnt     <= 4'd0;
         addr_r  <= '0;
         write_r <= 1'b0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         if (accept) begin
            addr_r  <= offset[AW+1:2];
            write_r <= HWRITE;
         end
      end
   end

   // Commit uses the old addr_r even when a new address is captured on the same edge.
   assign we     = (state == S_DATA) & write_r & ~rst;
   assign HRDATA = ((state == S_DATA) && !write_r) ? rd : 32'h0;

   sm_ahb_ram_array #(
      .SIZE (SIZE),
      .AW   (AW)
   ) u_array (
      .clk (clk),
      .we  (we),
      .wa  (addr_r),
      .wd  (HWDATA),
      .ra  (addr_r),
      .rd  (rd)
   );

endmodule

// File: tb/tb_sm_ahb_ram_slow.sv
// Randomized self-checking bench for sm_ahb_ram_slow against a transfer-level memory model.
module tb_sm_ahb_ram_slow;

   localparam int unsigned SIZE = 64;
   localparam logic [31:0] BASE = 32'h2000_0000;
   localparam int unsigned WC   = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        HSEL;
   logic [31:0] HADDR;
   logic        HWRITE;
   logic [1:0]  HTRANS;
   logic [31:0] HWDATA;
   logic        hready;
   logic [31:0] HRDATA;
   logic        HREADYOUT;
   logic        HRESP;
   logic        hready_low;

   int n_assert = 0;
   int n_fail   = 0;

   logic [31:0] mem_m [SIZE];
   logic [31:0] q_addr [64];
   logic [31:0] q_data [64];
   logic        q_write [64];

   assign hready = hready_low ? 1'b0 : HREADYOUT;

   always #5 clk = ~clk;

   sm_ahb_ram_slow #(
      .SIZE        (SIZE),
      .BASE        (BASE),
      .WAIT_CYCLES (WC)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .HSEL      (HSEL),
      .HADDR     (HADDR),
      .HWRITE    (HWRITE),
      .HTRANS    (HTRANS),
      .HWDATA    (HWDATA),
      .HREADY    (hready),
      .HRDATA    (HRDATA),
      .HREADYOUT (HREADYOUT),
      .HRESP     (HRESP)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_assert++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic bit model_err(input logic [31:0] addr);
      logic [31:0] off;
      off = addr - BASE;
`ifdef SM_AHB_RAM_ERR_EN
      return (off >= SIZE * 4) || (addr % 4 != 0);
`else
      return 1'b0;
`endif
   endfunction

   function automatic int model_idx(input logic [31:0] addr);
      logic [31:0] off;
      off = addr - BASE;
      return int'((off / 4) % SIZE);
   endfunction

   // Checks one finished data phase and advances the model in completion order.
   task automatic complete(input int i, input int cyc, input logic rdy1, input logic rsp1,
                           input logic rsp, input logic [31:0] rd);
      int idx;
      idx = model_idx(q_addr[i]);
      if (model_err(q_addr[i])) begin
         check("err_latency", 32'(cyc), 32'd2);
         check("err_ready1", {31'b0, rdy1}, 32'd0);
         check("err_resp1", {31'b0, rsp1}, 32'd1);
         check("err_resp2", {31'b0, rsp}, 32'd1);
      end else begin
         check("ok_latency", 32'(cyc), 32'(WC + 1));
         check("ok_resp", {31'b0, rsp}, 32'd0);
         if (q_write[i]) begin
            check("wr_rdata_zero", rd, 32'h0);
            mem_m[idx] = q_data[i];
         end else begin
            check("rdata", rd, mem_m[idx]);
         end
      end
   endtask

   task automatic drive_idle();
      HSEL   = 1'b0;
      HTRANS = 2'b00;
      HWRITE = 1'b0;
      HADDR  = 32'h0;
   endtask

   // Runs n queued transfers as a pipelined NONSEQ stream.
   task automatic run_seq(input int n);
      int ai, di, cyc, guard;
      logic rdy, rsp, rdy1, rsp1;
      logic [31:0] rd;
      ai = 0; di = -1; cyc = 0; guard = 0; rdy1 = 1'b0; rsp1 = 1'b0;
      @(posedge clk); #1;
      HSEL = 1'b1; HTRANS = 2'b10; HADDR = q_addr[0]; HWRITE = q_write[0];
      while ((ai < n || di >= 0) && guard < 2000) begin
         @(negedge clk);
         guard++;
         rdy = HREADYOUT; rsp = HRESP; rd = HRDATA;
         if (di >= 0) begin
            cyc++;
            if (cyc == 1) begin
               rdy1 = rdy;
               rsp1 = rsp;
            end
            if (rdy) complete(di, cyc, rdy1, rsp1, rsp, rd);
         end
         @(posedge clk); #1;
         if (rdy) begin
            di  = (ai < n) ? ai : -1;
            cyc = 0;
            if (di >= 0) HWDATA = q_data[di];
            if (ai < n) ai++;
            if (ai < n) begin
               HADDR = q_addr[ai]; HWRITE = q_write[ai];
            end else begin
               drive_idle();
            end
         end
      end
      if (guard >= 2000) check("seq_timeout", 32'd1, 32'd0);
      drive_idle();
   endtask

   task automatic push(input int i, input logic wr, input logic [31:0] a, input logic [31:0] d);
      q_write[i] = wr; q_addr[i] = a; q_data[i] = d;
   endtask

   initial begin
      int n;
      logic [31:0] a;
      rst = 1'b1; hready_low = 1'b0; HWDATA = 32'h0;
      drive_idle();
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_hreadyout", {31'b0, HREADYOUT}, 32'd1);
      check("rst_hresp", {31'b0, HRESP}, 32'd0);
      check("rst_hrdata", HRDATA, 32'h0);
      @(posedge clk); #1;
      rst = 1'b0;

      // Give every word a known value.
      for (int c = 0; c < SIZE / 16; c++) begin
         for (int i = 0; i < 16; i++) push(i, 1'b1, BASE + 32'((c * 16 + i) * 4), $urandom);
         run_seq(16);
      end

      push(0, 1'b1, 32'h2000_0004, 32'hDEAD_BEEF);
      push(1, 1'b0, 32'h2000_0004, 32'h0);
      run_seq(2);
      check("deadbeef_model", mem_m[1], 32'hDEAD_BEEF);

      for (int i = 0; i < 4; i++) push(i, 1'b1, BASE + 32'(i * 4), $urandom);
      for (int i = 0; i < 4; i++) push(4 + i, 1'b0, BASE + 32'(i * 4), 32'h0);
      push(8, 1'b1, BASE + 32'h10, 32'hCAFE_F00D);
      push(9, 1'b0, BASE + 32'h10, 32'h0);
      run_seq(10);

`ifdef SM_AHB_RAM_ERR_EN
      push(0, 1'b0, 32'h2000_0100, 32'h0);
      push(1, 1'b1, 32'h2000_0002, 32'h5555_AAAA);
      push(2, 1'b0, 32'h2000_0000, 32'h0);
      run_seq(3);
`else
      push(0, 1'b1, 32'h2000_0100, 32'h1111_1111);
      push(1, 1'b0, 32'h2000_0000, 32'h0);
      run_seq(2);
      check("wrap_model", mem_m[0], 32'h1111_1111);
`endif

      // Reset during the wait states of a write.
      @(posedge clk); #1;
      HSEL = 1'b1; HTRANS = 2'b10; HADDR = BASE + 32'h20; HWRITE = 1'b1;
      @(posedge clk); #1;
      drive_idle();
      HWDATA = 32'hA5A5_A5A5;
      @(negedge clk);
      check("rstw_wait", {31'b0, HREADYOUT}, 32'd0);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("rstw_hreadyout", {31'b0, HREADYOUT}, 32'd1);
      check("rstw_hresp", {31'b0, HRESP}, 32'd0);
      push(0, 1'b0, BASE + 32'h20, 32'h0);
      run_seq(1);

      // BUSY and external HREADY low must not start a transfer.
      @(posedge clk); #1;
      HSEL = 1'b1; HTRANS = 2'b01; HADDR = BASE + 32'h24; HWRITE = 1'b1; HWDATA = 32'h0BAD_0BAD;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("busy_hreadyout", {31'b0, HREADYOUT}, 32'd1);
      end
      @(posedge clk); #1;
      hready_low = 1'b1; HTRANS = 2'b10;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("hrdylow_hreadyout", {31'b0, HREADYOUT}, 32'd1);
      end
      @(posedge clk); #1;
      drive_idle();
      @(posedge clk); #1;
      hready_low = 1'b0;
      push(0, 1'b0, BASE + 32'h24, 32'h0);
      run_seq(1);

      for (int b = 0; b < 25; b++) begin
         n = int'($urandom_range(1, 8));
         for (int i = 0; i < n; i++) begin
            a = BASE + 32'($urandom_range(0, SIZE * 2 - 1) * 4);
            if ($urandom_range(0, 7) == 0) a = a + 32'($urandom_range(1, 3));
            push(i, 1'($urandom_range(0, 1)), a, $urandom);
         end
         run_seq(n);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
